// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex game engine: FSM states, cue LFSR taps,
// response-window width and the per-level window helper.
package reflex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_CUE,
    ST_JUDGE,
    ST_LEVEL_UP,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam int unsigned LFSR_W    = 16;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned MS_W      = 13;

  // Window for 1-based level lvl: max(win0 - (lvl-1)*step, wmin)
  function automatic logic [MS_W-1:0] level_window(input int unsigned lvl,
                                                   input int unsigned win0,
                                                   input int unsigned step,
                                                   input int unsigned wmin);
    int unsigned dec;
    dec = (lvl - 32'd1) * step;
    if (win0 < wmin + dec) return MS_W'(wmin);
    return MS_W'(win0 - dec);
  endfunction

endpackage

// File: rtl/reflex_cue_lfsr.sv
// 16-bit Galois LFSR that supplies cue codes; advances once per cue.
module reflex_cue_lfsr
  import reflex_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] lfsr_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= seed;
    end else if (advance) begin
      lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/reflex_game_ctrl.sv
// Ninja-Reflex game engine: cue sequencing, response judging, miss counting and
// level progression driven by a millisecond tick enable.
module reflex_game_ctrl
  import reflex_pkg::*;
#(
  parameter int unsigned       N_BTN          = 4,
  parameter int unsigned       N_LEVELS       = 3,
  parameter int unsigned       ACTS_PER_LEVEL = 15,
  parameter int unsigned       MAX_MISSES     = 3,
  parameter int unsigned       WIN0_MS        = 5000,
  parameter int unsigned       WIN_STEP_MS    = 1000,
  parameter int unsigned       WIN_MIN_MS     = 1000,
  parameter int unsigned       GAP_MS         = 500,
  parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick_ms,
  input  logic                              start,
  input  logic [N_BTN-1:0]                  btn_pulse,
  output logic [$clog2(N_BTN)-1:0]          cue,
  output logic                              cue_valid,
  output logic [$clog2(N_LEVELS+1)-1:0]     level,
  output logic [$clog2(ACTS_PER_LEVEL)-1:0] act_idx,
  output logic [$clog2(MAX_MISSES+1)-1:0]   misses,
  output logic                              hit_p,
  output logic                              miss_p,
  output logic [MS_W-1:0]                   ms_left,
  output logic                              win,
  output logic                              game_over
);

  localparam int unsigned CUE_W  = $clog2(N_BTN);
  localparam int unsigned LVL_W  = $clog2(N_LEVELS + 1);
  localparam int unsigned ACT_W  = $clog2(ACTS_PER_LEVEL);
  localparam int unsigned MISS_W = $clog2(MAX_MISSES + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_MS + 1);

  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [MS_W-1:0]   window;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_adv;
  logic              gap_done;
  logic [N_BTN-1:0]  cue_mask;
  logic              any_press;
  logic              press_ok;
  logic              timeout;

  reflex_cue_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .seed    (LFSR_SEED),
    .lfsr_q  (lfsr_q)
  );

  always_comb begin
    cue_mask      = '0;
    cue_mask[cue] = 1'b1;
  end

  assign gap_done  = (gap_cnt == GAP_W'(GAP_MS - 1));
  assign lfsr_adv  = (state == ST_GAP) && tick_ms && gap_done && !start;
  assign any_press = |btn_pulse;
  assign press_ok  = (btn_pulse == cue_mask);
  // Window expires on the tick that takes ms_left to zero
  assign timeout   = tick_ms && (ms_left == MS_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      window    <= '0;
      cue       <= '0;
      cue_valid <= 1'b0;
      level     <= '0;
      act_idx   <= '0;
      misses    <= '0;
      hit_p     <= 1'b0;
      miss_p    <= 1'b0;
      ms_left   <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit_p  <= 1'b0;
      miss_p <= 1'b0;
      if (start) begin
        state     <= ST_GAP;
        gap_cnt   <= '0;
        window    <= MS_W'(WIN0_MS);
        cue_valid <= 1'b0;
        level     <= LVL_W'(1);
        act_idx   <= '0;
        misses    <= '0;
        ms_left   <= '0;
        win       <= 1'b0;
        game_over <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_WIN, ST_LOSE: ;
          ST_GAP: begin
            if (tick_ms) begin
              if (gap_done) begin
                gap_cnt   <= '0;
                cue       <= CUE_W'(32'(lfsr_q) % N_BTN);
                cue_valid <= 1'b1;
                ms_left   <= window;
                state     <= ST_CUE;
              end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
              end
            end
          end
          ST_CUE: begin
            if (tick_ms) ms_left <= ms_left - MS_W'(1);
            // A press in the expiring cycle takes precedence over the timeout
            if (any_press) begin
              hit_p     <= press_ok;
              miss_p    <= !press_ok;
              cue_valid <= 1'b0;
              state     <= ST_JUDGE;
            end else if (timeout) begin
              miss_p    <= 1'b1;
              cue_valid <= 1'b0;
              state     <= ST_JUDGE;
            end
          end
          ST_JUDGE: begin
            // miss_p still holds the registered outcome of the judged cue
            if (miss_p && (misses == MISS_W'(MAX_MISSES - 1))) begin
              misses    <= misses + MISS_W'(1);
              game_over <= 1'b1;
              state     <= ST_LOSE;
            end else begin
              if (miss_p) misses <= misses + MISS_W'(1);
              if (act_idx == ACT_W'(ACTS_PER_LEVEL - 1)) begin
                if (level == LVL_W'(N_LEVELS)) begin
                  win   <= 1'b1;
                  state <= ST_WIN;
                end else begin
                  state <= ST_LEVEL_UP;
                end
              end else begin
                act_idx <= act_idx + ACT_W'(1);
                state   <= ST_GAP;
              end
            end
          end
          ST_LEVEL_UP: begin
            level   <= level + LVL_W'(1);
            act_idx <= '0;
            window  <= level_window(32'(level) + 32'd1, WIN0_MS, WIN_STEP_MS, WIN_MIN_MS);
            state   <= ST_GAP;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
